cycle_timer: RTL

CYCLE_TIMER -- requirements
Module: cycle_timer

---
 rtl/timer_pkg.sv | 23 ++
 rtl/cycle_timer_cfg.sv | 49 ++++
 rtl/cycle_timer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the cycle timer: state encoding, phase indices and
// the default phase duration.
package timer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int unsigned FILL  = 0;
  localparam int unsigned WASH  = 1;
  localparam int unsigned RINSE = 2;
  localparam int unsigned SPIN  = 3;
  localparam int unsigned DRAIN = 4;

  localparam int unsigned DEF_DUR_DEFAULT = 10;

  // Index width for an n-entry select; a single entry still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cycle_timer_cfg.sv
// Per-mode, per-phase duration table: synchronous write, asynchronous read,
// every entry reset to DEF_DUR.
module cycle_timer_cfg
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NPHASE  = 5,
  parameter int unsigned NMODE   = 4,
  parameter int unsigned DEF_DUR = DEF_DUR_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we_i,
  input  logic [idx_w(NMODE)-1:0]     wr_mode_i,
  input  logic [idx_w(NPHASE)-1:0]    wr_phase_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic [idx_w(NMODE)-1:0]     rd_mode_i,
  input  logic [idx_w(NPHASE)-1:0]    rd_phase_i,
  output logic [WIDTH-1:0]            rd_data_o
);

  localparam int unsigned MW = idx_w(NMODE);
  localparam int unsigned PW = idx_w(NPHASE);

  logic [WIDTH-1:0] dur_q [NMODE][NPHASE];

  // Decoding by exact match means out-of-range addresses hit no entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned m = 0; m < NMODE; m++)
        for (int unsigned p = 0; p < NPHASE; p++)
          dur_q[m][p] <= WIDTH'(DEF_DUR);
    end else if (we_i) begin
      for (int unsigned m = 0; m < NMODE; m++)
        for (int unsigned p = 0; p < NPHASE; p++)
          if (wr_mode_i == MW'(m) && wr_phase_i == PW'(p))
            dur_q[m][p] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned m = 0; m < NMODE; m++)
      for (int unsigned p = 0; p < NPHASE; p++)
        if (rd_mode_i == MW'(m) && rd_phase_i == PW'(p))
          rd_data_o = dur_q[m][p];
  end

endmodule

// File: rtl/cycle_timer.sv
// Multi-phase cycle timer: runs the phases of the selected program in order,
// counting each phase's duration down to zero, with pause and abort.
module cycle_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NPHASE  = 5,
  parameter int unsigned NMODE   = 4,
  parameter int unsigned DEF_DUR = DEF_DUR_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [idx_w(NMODE)-1:0]     load,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        abort,
  input  logic                        cfg_we,
  input  logic [idx_w(NMODE)-1:0]     cfg_mode,
  input  logic [idx_w(NPHASE)-1:0]    cfg_phase,
  input  logic [WIDTH-1:0]            cfg_data,
  output logic [WIDTH-1:0]            value,
  output logic [NPHASE-1:0]           phase_oh,
  output logic                        busy,
  output logic                        paused,
  output logic                        done
);

  localparam int unsigned MW = idx_w(NMODE);
  localparam int unsigned PW = idx_w(NPHASE);
  localparam logic [PW-1:0] LAST_PH = PW'(NPHASE - 1);

  logic [1:0]       state_q, state_d;
  logic [MW-1:0]    mode_q, mode_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [WIDTH-1:0] value_q, value_d;

  logic             accept;
  logic [MW-1:0]    rd_mode;
  logic [PW-1:0]    rd_phase;
  logic [WIDTH-1:0] rd_data;

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

  // One read port serves both the start load and the next-phase load;
  // they can never be needed in the same cycle.
  assign rd_mode  = accept ? load : mode_q;
  assign rd_phase = accept ? PW'(FILL) : phase_q + PW'(1);

  cycle_timer_cfg #(
    .WIDTH  (WIDTH),
    .NPHASE (NPHASE),
    .NMODE  (NMODE),
    .DEF_DUR(DEF_DUR)
  ) u_cfg (
    .clk       (clk),
    .reset     (reset),
    .we_i      (cfg_we),
    .wr_mode_i (cfg_mode),
    .wr_phase_i(cfg_phase),
    .wr_data_i (cfg_data),
    .rd_mode_i (rd_mode),
    .rd_phase_i(rd_phase),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    value_d = value_q;
    if (abort) begin
      state_d = ST_IDLE;
      phase_d = PW'(FILL);
      value_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            mode_d  = load;
            phase_d = PW'(FILL);
            value_d = rd_data;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (value_q != '0) begin
            value_d = value_q - WIDTH'(1);
          end else if (phase_q < LAST_PH) begin
            phase_d = phase_q + PW'(1);
            value_d = rd_data;
          end else begin
            state_d = ST_DONE;
            phase_d = PW'(FILL);
            value_d = '0;
          end
        end
        ST_PAUSE: begin
          if (!pause) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          value_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      phase_q <= PW'(FILL);
      value_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      value_q <= value_d;
    end
  end

  assign value  = value_q;
  assign busy   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign paused = (state_q == ST_PAUSE);
  assign done   = (state_q == ST_DONE);

  always_comb begin
    phase_oh = '0;
    for (int unsigned p = 0; p < NPHASE; p++)
      phase_oh[p] = busy && (phase_q == PW'(p));
  end

endmodule
